// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Request/response handshake bundle between a load/store
//                requester and the mem_responder memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Non-pipelined word memory responder with a fixed number of
//                wait states between request acceptance and RAM access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] C_LATENCY = 4'(LATENCY);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    write_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    w_capture;
    logic                    w_range_err;
    logic                    w_err;
    logic                    w_ram_we;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [31:0]             mem_q [DEPTH];

    // Any address bit above the RAM's word index makes the access out of range.
    generate
        if (ADDR_WIDTH + 2 < 32) begin : g_range_chk
            assign w_range_err = |addr_q[31:ADDR_WIDTH+2];
        end else begin : g_no_range_chk
            assign w_range_err = 1'b0;
        end
    endgenerate

    assign w_idx    = addr_q[ADDR_WIDTH+1:2];
    assign w_err    = (|addr_q[1:0]) | w_range_err;
    assign w_ram_we = (state_q == S_ACCESS) && write_q && !w_err && !reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        w_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_capture = 1'b1;
                    if (C_LATENCY == 4'd0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_LATENCY;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                err_d   = w_err;
                rdata_d = (write_q || w_err) ? 32'd0 : mem_q[w_idx];
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (w_capture) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // RAM contents survive reset; only the write enable is reset-qualified.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            mem_q[w_idx] <= wdata_q;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) && !reset;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the processor's load/store port. The processor side issues word requests over a valid/ready handshake. This block accepts each request and holds it for a fixed number of wait states. It then performs the access on an internal word RAM and returns read data plus an error flag over a second valid/ready handshake. It is used in the multicycle/stall-capable core and in bench environments to model slow data memory.

Parameters:
ADDR_WIDTH, 8, word-address width; RAM depth = 2**ADDR_WIDTH 32-bit words
LATENCY, 2, wait-state cycles between request acceptance and RAM access; legal range 0..15

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address; must be word-aligned
req_wdata  input  32  store data
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response this cycle
resp_rdata  output  32  load data; 0 for stores and errored requests
resp_err  output  1  request was misaligned or out of range
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: clk and reset are as stated in Ports (reset asynchronous, active-high).
  - State goes to IDLE. req_ready=1 once reset is deasserted; req_ready=0 while reset is high.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0.
  - RAM contents are not reset.
- States: IDLE, WAIT, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, capture write/addr/wdata into holding registers.
    - Next state is WAIT with counter=LATENCY, or ACCESS if LATENCY==0.
  - WAIT: counter decrements each cycle. Exactly LATENCY cycles are spent here, then go to ACCESS.
  - ACCESS: one cycle. Error check uses captured addr: err = (addr[1:0]!=0) | (addr[31:ADDR_WIDTH+2]!=0).
    - Store with no error: RAM[addr[ADDR_WIDTH+1:2]] <= wdata at the end of this cycle.
    - Load with no error: rdata register <= RAM word.
    - Errored request: no RAM write, rdata <= 0.
    - Store: rdata <= 0.
    - Then go to RESP.
  - RESP: resp_valid=1 with resp_rdata/resp_err stable. Hold until resp_ready=1, then go to IDLE.
    - resp_valid drops in the next cycle; resp_rdata/resp_err retain their values until the next ACCESS.
- Timing: if the handshake occurs in cycle 0, resp_valid first goes high in cycle LATENCY+2.
  - With resp_ready tied high, the next request can be accepted in cycle LATENCY+3.
  - There is no pipelining: req_ready=0 in WAIT/ACCESS/RESP, including the RESP cycle in which resp_ready=1.
- req_* inputs are ignored outside the IDLE handshake. Changes after acceptance do not affect the in-flight access.
- resp_ready is ignored outside RESP.
- Reset mid-operation: the in-flight request is discarded and no response is produced.
  - A store pending in WAIT is never written.
  - The RAM write enable is gated with !reset, so reset asserted during ACCESS suppresses the write.
- Address wrap: none. Out-of-range addresses report an error; they never alias.

Test Plan:
- LATENCY=2: store addr 0x10, data 0xDEADBEEF, handshake in cycle 0 -> resp_valid in cycle 4, err=0, rdata=0. A later load of 0x10 -> rdata=0xDEADBEEF, err=0.
- LATENCY=0: load 0x10 -> resp_valid in cycle 2. Hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay stable and req_ready=0 throughout. Then resp_ready=1 -> req_ready=1 in the next cycle.
- Misaligned store addr 0x12, data 0x12345678 -> err=1, rdata=0. A subsequent load of 0x10 still returns the previous value.
- ADDR_WIDTH=8: load addr 0x400 -> err=1, rdata=0. Store to 0x3FC with data 0xA5A5A5A5, then load 0x3FC -> 0xA5A5A5A5, err=0.
- Store 0x20, data 0x11111111, with reset pulsed during the WAIT cycle -> no response; busy=0 and req_ready=1 after reset. Load 0x20 -> the old value, not 0x11111111.
- Back-to-back: req_valid held high with 4 loads at addresses 0x0, 0x4, 0x8 and 0xC, resp_ready=1, LATENCY=1 -> handshakes exactly every 4 cycles, responses in order with the correct data.
